uart_rx_param: RTL and testbench

Parametrised serial receiver: the next generation of the team's one-bit-per-clock UART receiver. It oversamples an asynchronous `rxd` line and checks start, parity and stop bits. Each received word goes into a holding register drained through a valid/ready handshake, with per-word error flags. It sits between the board RX pin and the command/data path consuming received bytes.

---
 rtl/uart_pkg.sv | 38 +++
 rtl/sync2.sv | 38 +++
 rtl/uart_rx_param.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the parametrised UART receiver:
//               receive FSM state encoding, parity mode constants, the
//               serial idle level and a parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receive FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_BREAK = 3'd5
  } rx_state_e;

  // Parity modes
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Level of an idle (marking) serial line
  localparam logic IDLE_LEVEL = 1'b1;

  // Widest data word the receiver supports
  localparam int MAX_DATA_BITS = 9;

  // XOR-reduction of a (zero-extended) data word
  function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] v);
    return ^v;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer for a single asynchronous input.
//               Both flops reset to RESET_VAL so an idle-high line does not
//               show a spurious edge coming out of reset.
// Ports       : clk  - clock
//               rst  - asynchronous active-low reset
//               d_i  - asynchronous input
//               q_o  - synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : sync2
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_param
// Description : Parametrised oversampling UART receiver. Detects the start
//               bit, samples data/parity/stop bits at mid-bit, and presents
//               each word in a holding register drained by valid/ready.
// Ports       : clk        - clock (rising edge)
//               rst        - asynchronous active-low reset
//               rxd        - asynchronous serial input, idle high
//               data_out   - held received word
//               data_valid - data_out and error flags are valid
//               data_ready - consumer accepts the held word
//               parity_err - parity mismatch for the held word
//               frame_err  - stop bit sampled low for the held word
//               overrun    - one-cycle pulse when a completed word is dropped
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int MSB_FIRST  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 rxs;

  rx_state_e            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_pend_q, perr_pend_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 w_tick_wrap;
  logic                 w_word_done;
  logic                 w_par_xor;

  sync2 #(
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync_rxd (
    .clk (clk),
    .rst (rst),
    .d_i (rxd),
    .q_o (rxs)
  );

  // Bit order of the shift register: MSB-first shifts left so the first
  // received bit ends up in the top position after DATA_BITS samples.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_shift_nxt = {shift_q[DATA_BITS-2:0], rxs};
    end else begin : g_lsb_first
      assign w_shift_nxt = {rxs, shift_q[DATA_BITS-1:1]};
    end
  endgenerate

  assign w_tick_wrap = (tick_q == TICK_LAST);
  assign w_par_xor   = calc_parity(MAX_DATA_BITS'(shift_q)) ^ rxs;

  always_comb begin
    state_d     = state_q;
    tick_d      = w_tick_wrap ? '0 : tick_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    w_word_done = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tick_d      = '0;
        bit_d       = '0;
        perr_pend_d = 1'b0;
        if (rxs != IDLE_LEVEL) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        // Re-check the line at mid start bit to reject glitches
        if (tick_q == TICK_HALF) begin
          if (rxs == IDLE_LEVEL) begin
            state_d = ST_IDLE;
          end else begin
            tick_d  = '0;
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (w_tick_wrap) begin
          shift_d = w_shift_nxt;
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end
        end
      end

      ST_PAR: begin
        if (w_tick_wrap) begin
          perr_pend_d = (PARITY == PAR_ODD) ? ~w_par_xor : w_par_xor;
          state_d     = ST_STOP;
        end
      end

      ST_STOP: begin
        if (w_tick_wrap) begin
          w_word_done = 1'b1;
          state_d     = (rxs == IDLE_LEVEL) ? ST_IDLE : ST_BREAK;
        end
      end

      ST_BREAK: begin
        // Line held low past the stop bit: ignore it until it recovers
        tick_d = '0;
        if (rxs == IDLE_LEVEL) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Holding register and handshake
  always_comb begin
    data_out_d = data_out_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    valid_d    = valid_q & ~data_ready;
    ovr_d      = 1'b0;

    if (w_word_done) begin
      // An accept in the same cycle frees the register for the new word
      if (!valid_q || data_ready) begin
        data_out_d = shift_q;
        perr_d     = (PARITY != PAR_NONE) ? perr_pend_q : 1'b0;
        ferr_d     = ~rxs;
        valid_d    = 1'b1;
      end else begin
        ovr_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule : uart_rx_param
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_param
// Description : Scoreboard bench for uart_rx_param. Three receivers with
//               OVERSAMPLE=4, DATA_BITS=8:
//                 [0] no parity, MSB first
//                 [1] even parity, MSB first
//                 [2] even parity, LSB first
//               Directed frames push expected words; a monitor pops and
//               compares each word the DUT presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_param;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [2:0] rxd_v;
  logic       ready [3];
  logic [7:0] dout  [3];
  logic       valid [3];
  logic       perr  [3];
  logic       ferr  [3];
  logic       ovr   [3];

  exp_t exp_q [3][$];
  int   ovr_cnt [3];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(4), .PARITY(0), .MSB_FIRST(1)) u_dut_a (
    .clk(clk), .rst(rst), .rxd(rxd_v[0]), .data_out(dout[0]), .data_valid(valid[0]),
    .data_ready(ready[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(4), .PARITY(1), .MSB_FIRST(1)) u_dut_b (
    .clk(clk), .rst(rst), .rxd(rxd_v[1]), .data_out(dout[1]), .data_valid(valid[1]),
    .data_ready(ready[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(4), .PARITY(1), .MSB_FIRST(0)) u_dut_c (
    .clk(clk), .rst(rst), .rxd(rxd_v[2]), .data_out(dout[2]), .data_valid(valid[2]),
    .data_ready(ready[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, got, req);
    end
  endtask

  // Advance n rising edges, then settle 2 ns past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int idx, input logic [7:0] d, input logic pe, input logic fe, input int c);
    exp_t e;
    e.data = d; e.perr = pe; e.ferr = fe; e.cyc = c;
    exp_q[idx].push_back(e);
  endtask

  // One frame, 4 cycles per bit
  task automatic send_frame(input int idx, input logic [7:0] d, input bit msb, input bit has_par,
                            input bit pbit, input bit stop_bit, input bit idle_after);
    rxd_v[idx] = 1'b0;
    step(4);
    for (int b = 0; b < 8; b++) begin
      rxd_v[idx] = msb ? d[7-b] : d[b];
      step(4);
    end
    if (has_par) begin
      rxd_v[idx] = pbit;
      step(4);
    end
    rxd_v[idx] = stop_bit;
    step(4);
    if (idle_after) rxd_v[idx] = 1'b1;
  endtask

  // Pops one expected word each time a receiver presents a new word
  task automatic monitor_loop();
    exp_t e;
    logic pv   [3];
    logic pacc [3];
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pacc[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (ovr[i] === 1'b1) ovr_cnt[i]++;
        if (valid[i] === 1'b1 && (!pv[i] || pacc[i])) begin
          if (exp_q[i].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL rx%0d_unexpected_word: got data %0h, required no word", i, dout[i]);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("rx%0d_data", i), 32'(dout[i]), 32'(e.data));
            chk($sformatf("rx%0d_parity_err", i), 32'(perr[i]), 32'(e.perr));
            chk($sformatf("rx%0d_frame_err", i), 32'(ferr[i]), 32'(e.ferr));
            if (e.cyc >= 0) chk($sformatf("rx%0d_valid_cycle", i), cyc, e.cyc);
          end
        end
        pv[i]   = valid[i];
        pacc[i] = valid[i] & ready[i];
      end
    end
  endtask

  initial begin
    rst   = 1'b0;
    rxd_v = 3'b111;
    for (int i = 0; i < 3; i++) begin
      ready[i]   = 1'b1;
      ovr_cnt[i] = 0;
    end
    fork
      monitor_loop();
    join_none

    // Reset state
    step(3);
    chk("reset_data_out", 32'(dout[0]), 32'h0);
    chk("reset_data_valid", 32'(valid[0]), 32'h0);
    chk("reset_parity_err", 32'(perr[0]), 32'h0);
    chk("reset_frame_err", 32'(ferr[0]), 32'h0);
    chk("reset_overrun", 32'(ovr[0]), 32'h0);
    rst = 1'b1;
    step(3);

    // 1. Clean frame: valid 41 cycles after the first low sample, one cycle wide
    push(0, 8'hA5, 1'b0, 1'b0, cyc + 1 + 41);
    send_frame(0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(3);
    @(negedge clk);
    chk("clean_valid_one_cycle", 32'(valid[0]), 32'h0);
    step(4);

    // 2. One-cycle glitch is rejected, then a real frame
    rxd_v[0] = 1'b0;
    step(1);
    rxd_v[0] = 1'b1;
    step(12);
    chk("glitch_no_valid", 32'(valid[0]), 32'h0);
    push(0, 8'h3C, 1'b0, 1'b0, -1);
    send_frame(0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(4);

    // 3. Even parity: 0x07 has three ones, so parity bit 0 is wrong
    push(1, 8'h07, 1'b1, 1'b0, -1);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(4);
    push(1, 8'h07, 1'b0, 1'b0, -1);
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(4);
    push(2, 8'h07, 1'b0, 1'b0, -1);
    send_frame(2, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(4);

    // 4. Low stop bit, line held low: one word with frame error, nothing more
    push(0, 8'h55, 1'b0, 1'b1, -1);
    send_frame(0, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(20);
    rxd_v[0] = 1'b1;
    step(60);
    push(0, 8'h81, 1'b0, 1'b0, -1);
    send_frame(0, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(4);

    // 5. Overrun: second word dropped while the first is held
    ready[0] = 1'b0;
    push(0, 8'h11, 1'b0, 1'b0, -1);
    send_frame(0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(2);
    send_frame(0, 8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(4);
    chk("overrun_pulse_count", ovr_cnt[0], 1);
    chk("overrun_held_data", 32'(dout[0]), 32'h11);
    chk("overrun_held_valid", 32'(valid[0]), 32'h1);
    ready[0] = 1'b1;
    @(negedge clk);
    chk("accept_valid_same_cycle", 32'(valid[0]), 32'h1);
    step(1);
    @(negedge clk);
    chk("accept_valid_dropped", 32'(valid[0]), 32'h0);
    step(2);

    // 6. Asynchronous reset during data bit 4 with a word held
    ready[0] = 1'b0;
    push(0, 8'h5A, 1'b0, 1'b0, -1);
    send_frame(0, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(4);
    chk("pre_reset_valid", 32'(valid[0]), 32'h1);
    fork
      send_frame(0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      begin
        step(22);
        #1;
        rst = 1'b0;
        #1;
        chk("async_reset_data_out", 32'(dout[0]), 32'h0);
        chk("async_reset_valid", 32'(valid[0]), 32'h0);
        chk("async_reset_frame_err", 32'(ferr[0]), 32'h0);
        chk("async_reset_overrun", 32'(ovr[0]), 32'h0);
      end
    join
    step(4);
    rst = 1'b1;
    ready[0] = 1'b1;
    step(4);
    push(0, 8'hC3, 1'b0, 1'b0, -1);
    send_frame(0, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(6);

    // Every expected word must have been presented
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rx%0d_pending_words", i), exp_q[i].size(), 0);
    end
    chk("rx1_overrun_count", ovr_cnt[1], 0);
    chk("rx2_overrun_count", ovr_cnt[2], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_uart_rx_param
`default_nettype wire
